// File: rtl/noc_output_port_allocator.sv
// Switch allocator for one router output port.
// Round-robin arbitration among head flits, wormhole locking until the
// packet's tail passes, and a downstream credit counter that gates every grant.
//
// Handshake: a flit moves (fire) only in a cycle where the selected input
// has req set, grant is asserted for it, and out_ready is high. A grant
// without fire changes nothing and is re-evaluated the next cycle.
module noc_output_port_allocator #(
    parameter int NUM_REQ      = 5,
    parameter int CREDIT_DEPTH = 4,
    localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1),
    localparam int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_head,
    input  logic [NUM_REQ-1:0] req_tail,
    input  logic               out_ready,
    input  logic               credit_return,
    output logic [NUM_REQ-1:0] grant,
    output logic               fire,
    output logic               locked,
    output logic [OWN_W-1:0]   owner,
    output logic [CNT_W-1:0]   credit_count,
    output logic               credit_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_DEPTH);

    logic [0:0]         state;
    logic [OWN_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [OWN_W-1:0]   win_idx;

    assign eligible = req & req_head;
    assign locked   = (state == ST_LOCKED);

    // Round-robin search for the first eligible head after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(idx);
            end
        end
    end

    // Grant selection: winner when idle, owner only when locked, none without credit.
    always_comb begin
        grant = '0;
        if (noc_rst_n && credit_count != '0) begin
            if (state == ST_IDLE) begin
                if (win_found) grant = NUM_REQ'(1) << win_idx;
            end else if (req[owner]) begin
                grant = NUM_REQ'(1) << owner;
            end
        end
    end

    assign fire = (|(grant & req)) & out_ready;

    // Ownership FSM and round-robin pointer; both advance only on a transfer.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= OWN_W'(NUM_REQ - 1);
        end else if (fire) begin
            if (state == ST_IDLE) begin
                rr_ptr <= win_idx;
                // A single-flit packet (head and tail together) never locks.
                if (!req_tail[win_idx]) begin
                    state <= ST_LOCKED;
                    owner <= win_idx;
                end
            end else if (req_tail[owner]) begin
                state <= ST_IDLE;
                owner <= '0;
            end
        end
    end

    // Credit counter: spend on fire, refill on return, flag returns beyond capacity.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            credit_count <= CNT_FULL;
            credit_err   <= 1'b0;
        end else begin
            case ({fire, credit_return})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count == CNT_FULL) credit_err <= 1'b1;
                    else credit_count <= credit_count + 1'b1;
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

endmodule
